// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared multdiv constants and divider state encoding
package seq_divider_pkg;
   localparam int WIDTH = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;
endpackage

// File: rtl/cla_adder.sv
// cla_adder: carry-lookahead adder, sum = a + b + cin
//   a, b : addends   cin : carry in   sum : result (carry out dropped)
module cla_adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum
);
   logic [W-1:0] g, p, c;
   assign g = a & b;
   assign p = a ^ b;
   always_comb begin
      c[0] = cin;
      for (int i = 1; i < W; i++) c[i] = g[i-1] | (p[i-1] & c[i-1]);
   end
   assign sum = p ^ c;
endmodule

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one restoring shift-subtract iteration on magnitudes
//   r_i, q_i : partial remainder and quotient/dividend shift register
//   d_i      : divisor magnitude
//   r_o, q_o : values after shift, trial subtract and restore
module seq_divider_div_step #(
   parameter int WIDTH = seq_divider_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] r_o,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH:0] rem_s, trial;
   assign rem_s = {r_i, q_i[WIDTH-1]};
   // r_i < d_i keeps the trial within (-2^WIDTH, 2^WIDTH), so bit WIDTH is an exact sign
   cla_adder #(.W(WIDTH+1)) u_sub (
      .a  (rem_s),
      .b  (~{1'b0, d_i}),
      .cin(1'b1),
      .sum(trial)
   );
   assign r_o = trial[WIDTH] ? rem_s[WIDTH-1:0] : trial[WIDTH-1:0];
   assign q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider, quotient truncated toward zero
//   clock, reset_n          : rising-edge clock, async active-low reset
//   ctrl_DIV                : start strobe, ignored while busy
//   data_operandA/B         : dividend / divisor, sampled with ctrl_DIV
//   data_result             : quotient, held until next accepted start
//   data_exception          : divide-by-zero or INT_MIN/-1 overflow
//   data_resultRDY          : one-cycle result-valid pulse
//   busy                    : operation in flight
module seq_divider #(
   parameter int WIDTH = seq_divider_pkg::WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   import seq_divider_pkg::*;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, res_q, res_d;
   logic             sign_q, sign_d, exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
   logic [WIDTH-1:0] neg_a, neg_b, neg_q, r_nx, q_nx;
   cla_adder #(.W(WIDTH)) u_neg_a (.a(~data_operandA), .b('0), .cin(1'b1), .sum(neg_a));
   cla_adder #(.W(WIDTH)) u_neg_b (.a(~data_operandB), .b('0), .cin(1'b1), .sum(neg_b));
   cla_adder #(.W(WIDTH)) u_neg_q (.a(~q_q), .b('0), .cin(1'b1), .sum(neg_q));
   seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
      .r_i(r_q),
      .q_i(q_q),
      .d_i(d_q),
      .r_o(r_nx),
      .q_o(q_nx)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      sign_d  = sign_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
      case (state_q)
         S_IDLE: if (ctrl_DIV) begin
            q_d    = data_operandA[WIDTH-1] ? neg_a : data_operandA;
            d_d    = data_operandB[WIDTH-1] ? neg_b : data_operandB;
            r_d    = '0;
            cnt_d  = '0;
            sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            exc_d  = data_operandB == '0;
            if (data_operandB == '0) begin
               res_d = '0;
               rdy_d = 1'b1;
            end else begin
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            r_d     = r_nx;
            q_d     = q_nx;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = cnt_q == CNT_W'(WIDTH-1) ? S_FIX : S_CALC;
         end
         S_FIX: begin
            res_d   = sign_q ? neg_q : q_q;
            // a positive quotient of magnitude INT_MIN only arises from INT_MIN / -1
            exc_d   = ~sign_q & (q_q == WIDTH'(INT_MIN));
            rdy_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = state_d != S_IDLE;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         sign_q  <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         sign_q  <= sign_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end
   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider
module tb_seq_divider;
   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, busy;
   int          cyc = 0, free_at = 0, clr_at = -1, bz_lo = 0, bz_hi = 0;
   int          errors = 0, checks = 0;
   logic [31:0] hres = '0;
   logic        hexc = 1'b0;
   exp_t        sb[$];

   seq_divider dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .ctrl_DIV      (ctrl_DIV),
      .data_operandA (op_a),
      .data_operandB (op_b),
      .data_result   (data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .busy          (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb_, q;
      if (b == 32'h0) return {1'b1, 32'h0};
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      q = sa / sb_;
      return {(a == 32'h8000_0000 && b == 32'hFFFF_FFFF), q[31:0]};
   endfunction

   // called at a negedge; presents a start for one cycle and returns at the next negedge
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      int          n;
      logic [32:0] m;
      exp_t        e;
      ctrl_DIV = 1'b1;
      op_a = a;
      op_b = b;
      n = cyc + 1;
      if (n >= free_at) begin
         m = model(a, b);
         e.res = m[31:0];
         e.exc = m[32];
         e.cyc = n + (b == 0 ? 0 : 33);
         sb.push_back(e);
         free_at = e.cyc + 1;
         clr_at = n;
         bz_lo = n;
         bz_hi = b == 0 ? n : n + 33;
      end
      @(negedge clock);
      ctrl_DIV = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
   endtask

   task automatic wait_free();
      while (cyc + 1 < free_at) @(negedge clock);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_result", data_result, 32'h0);
      chk("rst_exc", {31'h0, data_exception}, 32'h0);
      chk("rst_rdy", {31'h0, data_resultRDY}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      sb.delete();
      free_at = 0;
      clr_at = -1;
      bz_lo = 0;
      bz_hi = 0;
      hres = '0;
      hexc = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // monitor: compares against the scoreboard and the held-output model
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (cyc == clr_at) hexc = 1'b0;
         if (data_resultRDY) begin
            if (sb.size() == 0) begin
               chk("spurious_rdy", 32'h1, 32'h0);
            end else begin
               e = sb.pop_front();
               chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
               chk("result", data_result, e.res);
               chk("exception", {31'h0, data_exception}, {31'h0, e.exc});
               hres = e.res;
               hexc = e.exc;
            end
         end else begin
            if (sb.size() != 0 && cyc > sb[0].cyc) begin
               chk("rdy_timeout", 32'(cyc), 32'(sb[0].cyc));
               void'(sb.pop_front());
            end
            chk("hold_result", data_result, hres);
            chk("hold_exc", {31'h0, data_exception}, {31'h0, hexc});
         end
         chk("busy", {31'h0, busy}, {31'h0, (cyc >= bz_lo && cyc < bz_hi)});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 50000", cyc);
      $fatal(1);
   end

   initial begin
      int mode;
      logic [31:0] a, b;
      repeat (3) @(negedge clock);
      chk("rst_result", data_result, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);
      wait_free(); issue(32'd100, 32'd7);
      wait_free(); issue(32'hFFFF_FF9C, 32'd7);
      wait_free(); issue(32'd7, 32'hFFFF_FF9C);
      wait_free(); issue(32'hFFFF_FFF9, 32'hFFFF_FFFE);
      wait_free(); issue(32'd5, 32'd0);
      issue(32'd12, 32'd0);
      wait_free(); issue(32'h8000_0000, 32'hFFFF_FFFF);
      wait_free(); issue(32'h8000_0000, 32'd2);
      wait_free(); issue(32'd100, 32'd7);
      repeat (8) @(negedge clock);
      issue(32'd9, 32'd3);
      wait_free(); issue(32'd9, 32'd3);
      wait_free(); issue(32'd100, 32'd7);
      repeat (13) @(negedge clock);
      pulse_reset();
      repeat (40) @(negedge clock);
      issue(32'd50, 32'd5);
      for (int k = 0; k < 40; k++) begin
         mode = $urandom_range(0, 7);
         a = (mode == 1) ? 32'h8000_0000 : $urandom;
         b = (mode == 0) ? 32'h0 : (mode == 1) ? 32'hFFFF_FFFF :
             (mode < 5) ? 32'($signed(16'($urandom))) : $urandom;
         if (mode == 6) a = 32'($signed(12'($urandom)));
         wait_free();
         repeat ($urandom_range(0, 2)) @(negedge clock);
         issue(a, b);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 20)) @(negedge clock);
            issue($urandom, $urandom_range(1, 50));
         end
      end
      wait_free();
      repeat (3) @(negedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
